uart_rx_ctrl: RTL and testbench

//  Sequencing controller for the UART receive path. Oversamples rx on clk (OVS ticks per bit).

---
 rtl/uart_rx_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: oversampled start/data/stop detection with valid/ready byte output.
// Optional UART_RX_PARITY_EN inserts an even-parity bit between data and stop and adds par_err.
module uart_rx_ctrl #(
    parameter int OVS       = 20,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 frm_err,
`ifdef UART_RX_PARITY_EN
    output logic                 par_err,
`endif
    output logic                 ovr_err
);

    localparam int CW = $clog2(OVS);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_MID = CW'(OVS/2 - 1);
    localparam logic [CW-1:0] CNT_END = CW'(OVS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

    state_t               state, state_nxt;
    logic [1:0]           sync;
    logic                 rxs;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 smp, stop_smp, good;

    assign rxs = sync[1];

    // rx is asynchronous to clk; the line idles high so the flops reset high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= 2'b11;
        else      sync <= {sync[0], rx};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        smp       = 1'b0;
        stop_smp  = 1'b0;
        case (state)
            IDLE:  if (!rxs) state_nxt = START;
            START: if (cnt == CNT_MID) begin
                       smp       = 1'b1;
                       state_nxt = rxs ? IDLE : DATA;
                   end
            DATA:  if (cnt == CNT_END) begin
                       smp = 1'b1;
`ifdef UART_RX_PARITY_EN
                       if (idx == IW'(DATA_BITS-1)) state_nxt = PARITY;
`else
                       if (idx == IW'(DATA_BITS-1)) state_nxt = STOP;
`endif
                   end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt == CNT_END) begin
                        smp       = 1'b1;
                        state_nxt = STOP;
                    end
`endif
            STOP:  if (cnt == CNT_END) begin
                       smp       = 1'b1;
                       stop_smp  = 1'b1;
                       state_nxt = rxs ? IDLE : BRK;
                   end
            BRK:   if (rxs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter restarts at every sample point so each bit is timed from the previous sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            if (smp || state == IDLE || state == BRK) cnt <= '0;
            else                                      cnt <= cnt + CW'(1);
            if (state != DATA) idx <= '0;
            else if (smp)      idx <= idx + IW'(1);
            if (state == DATA && smp) shreg <= {rxs, shreg[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        par_bad <= 1'b0;
        else if (state == START)         par_bad <= 1'b0;
        else if (state == PARITY && smp) par_bad <= (rxs != ^shreg);
    end

    // Parity is only reported once the stop bit is known good
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_err <= 1'b0;
        else      par_err <= stop_smp & rxs & par_bad;
    end

    assign good = stop_smp & rxs & ~par_bad;
`else
    assign good = stop_smp & rxs;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            frm_err   <= 1'b0;
            ovr_err   <= 1'b0;
        end else begin
            busy    <= (state_nxt != IDLE);
            frm_err <= stop_smp & ~rxs;
            ovr_err <= 1'b0;
            if (good) begin
                // A byte accepted this cycle frees the slot for the new one
                if (!out_valid || out_ready) begin
                    out_data  <= shreg;
                    out_valid <= 1'b1;
                end else begin
                    ovr_err <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: table-driven frames with a byte scoreboard plus corner-case sequences.
module tb_uart_rx_ctrl;
    localparam int OVS = 20;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int EXP_LAT = OVS/2 + (DB + 1 + (PAR ? 1 : 0)) * OVS;

    logic          clk = 1'b0, rst = 1'b0, rx = 1'b1, out_ready = 1'b0;
    logic [DB-1:0] out_data;
    logic          out_valid, busy, frm_err, ovr_err;
`ifdef UART_RX_PARITY_EN
    logic          par_err;
`endif

    uart_rx_ctrl #(.OVS(OVS), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frm_err(frm_err),
`ifdef UART_RX_PARITY_EN
        .par_err(par_err),
`endif
        .ovr_err(ovr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       ok;
    } vec_t;

    vec_t       vt[7];
    logic [7:0] exp_q[$];
    int checks = 0, errors = 0;
    int cyc = 0, frm_cnt = 0, ovr_cnt = 0, par_cnt = 0, vld_cyc = 0;
    int t_busy = 0, t_ov = 0;
    logic busy_q = 0, ov_q = 0, frm_q = 0, ovr_q = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves rx at the stop level; the caller decides what the line does next
    task automatic send(input logic [7:0] d, input logic stop, input logic par);
        rx = 1'b0; tick(OVS);
        for (int i = 0; i < DB; i++) begin
            rx = d[i]; tick(OVS);
        end
        if (PAR) begin
            rx = par; tick(OVS);
        end
        rx = stop; tick(OVS);
    endtask

    initial begin
        vt[0] = '{8'hA5, 1'b1, 1'b1};
        vt[1] = '{8'h00, 1'b1, 1'b1};
        vt[2] = '{8'hFF, 1'b1, 1'b1};
        vt[3] = '{8'h3C, 1'b0, 1'b0};
        vt[4] = '{8'h5A, 1'b1, 1'b1};
        vt[5] = '{8'h80, 1'b1, 1'b1};
        vt[6] = '{8'h01, 1'b1, 1'b1};

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (out_valid) vld_cyc++;
                if (busy && !busy_q) t_busy = cyc;
                if (out_valid && !ov_q) t_ov = cyc;
                if (frm_err) begin frm_cnt++; chk("frm_pulse_width", frm_q, 0); end
                if (ovr_err) begin ovr_cnt++; chk("ovr_pulse_width", ovr_q, 0); end
`ifdef UART_RX_PARITY_EN
                if (par_err) par_cnt++;
`endif
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_byte actual=%0h required=none", out_data);
                    end else begin
                        chk("sb_data", out_data, exp_q.pop_front());
                    end
                end
                busy_q = busy; ov_q = out_valid; frm_q = frm_err; ovr_q = ovr_err;
            end
        join_none

        // Reset state
        tick(3);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {frm_err, ovr_err}, 0);
        rst = 1'b1;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 100; i++) begin tick(1); seen |= busy; end
            chk("idle_busy_100", seen, 0);
        end

        // Frame table, consumer always ready
        out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            int f0, v0;
            f0 = frm_cnt; v0 = vld_cyc;
            if (vt[v].ok) exp_q.push_back(vt[v].d);
            send(vt[v].d, vt[v].stop, ^vt[v].d);
            rx = 1'b1;
            tick(40);
            chk($sformatf("frm_cnt[%0d]", v), frm_cnt - f0, vt[v].ok ? 0 : 1);
            chk($sformatf("vld_cycles[%0d]", v), vld_cyc - v0, vt[v].ok ? 1 : 0);
            chk($sformatf("sb_drained[%0d]", v), exp_q.size(), 0);
            if (vt[v].ok) chk($sformatf("latency[%0d]", v), t_ov - t_busy, EXP_LAT);
            chk($sformatf("busy_idle[%0d]", v), busy, 0);
        end

        // False start: glitch shorter than half a bit
        begin
            int v0, b0;
            v0 = vld_cyc; b0 = t_busy;
            rx = 1'b0; tick(5); rx = 1'b1;
            tick(30);
            chk("false_start_busy_seen", t_busy != b0, 1);
            chk("false_start_busy", busy, 0);
            chk("false_start_no_valid", vld_cyc - v0, 0);
        end

        // Framing error followed by a held-low line
        begin
            int f0;
            f0 = frm_cnt;
            send(8'h3C, 1'b0, ^8'h3C);
            tick(200);
            chk("brk_busy", busy, 1);
            chk("brk_frm_once", frm_cnt - f0, 1);
            rx = 1'b1;
            tick(5);
            chk("brk_exit_busy", busy, 0);
        end

        // Overrun: second byte dropped, first byte preserved
        begin
            int o0;
            o0 = ovr_cnt;
            out_ready = 1'b0;
            exp_q.push_back(8'h11);
            send(8'h11, 1'b1, ^8'h11); rx = 1'b1; tick(10);
            send(8'h22, 1'b1, ^8'h22); rx = 1'b1; tick(20);
            chk("ovr_pulse", ovr_cnt - o0, 1);
            chk("ovr_keep_data", out_data, 8'h11);
            chk("ovr_valid_held", out_valid, 1);
            out_ready = 1'b1;
            tick(3);
            chk("ovr_accepted", out_valid, 0);
            chk("ovr_sb_drained", exp_q.size(), 0);
        end

        // Reset mid-DATA with a pending byte
        out_ready = 1'b0;
        send(8'h5A, 1'b1, ^8'h5A); rx = 1'b1; tick(10);
        chk("pending_valid", out_valid, 1);
        rx = 1'b0; tick(60);
        rst = 1'b0; #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", out_data, 0);
        rx = 1'b1; tick(3);
        rst = 1'b1; tick(30);
        chk("post_rst_busy", busy, 0);
        out_ready = 1'b1;

`ifdef UART_RX_PARITY_EN
        begin
            int p0, f0, v0;
            p0 = par_cnt; f0 = frm_cnt; v0 = vld_cyc;
            send(8'h07, 1'b1, ~^8'h07); rx = 1'b1; tick(40);
            chk("par_err_pulse", par_cnt - p0, 1);
            chk("par_no_valid", vld_cyc - v0, 0);
            p0 = par_cnt;
            send(8'h07, 1'b0, ~^8'h07); rx = 1'b1; tick(40);
            chk("par_frm_only_frm", frm_cnt - f0, 1);
            chk("par_frm_only_par", par_cnt - p0, 0);
        end
`endif

        chk("sb_final_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
